// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
// imem_responder_if : fetch request/response and loader signal bundle
// Rev 1.0
// ============================================================================
interface imem_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              flush;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_instr;
   logic              rsp_err;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;

   modport master (
      output req_valid, req_addr, flush, ld_en, ld_addr, ld_data,
      input  req_ready, rsp_valid, rsp_instr, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, flush, ld_en, ld_addr, ld_data,
      output req_ready, rsp_valid, rsp_instr, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// imem_responder : instruction memory responder with configurable wait states;
//                  one-word line buffer enabled by macro IMEM_LINEBUF_EN
// Rev 1.0
// ============================================================================
module imem_responder #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 1024,
   parameter int WAIT_CYC = 2
) (
   input wire              clk,
   input wire              rst,
   imem_responder_if.slave bus
);
   localparam int IDX_W  = ADDR_W - 2;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0]     c_IDLE      = 2'd0;
   localparam logic [1:0]     c_WAIT      = 2'd1;
   localparam logic [1:0]     c_RESP      = 2'd2;
   localparam logic [IDX_W:0] c_DEPTH     = (IDX_W + 1)'(DEPTH);
   localparam logic [3:0]     c_WAIT_LOAD = 4'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);
   localparam logic           c_ZERO_WAIT = (WAIT_CYC == 0);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [MEM_AW-1:0] idx_q;
   logic [DATA_W-1:0] rsp_instr_q;
   logic              rsp_err_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  w_req_idx;
   logic [IDX_W-1:0]  w_ld_idx;
   logic              w_req_err;
   logic              w_ready;
   logic              w_accept;
   logic              w_wait_done;
   logic              w_miss_rd;
   logic              w_ld_ok;
   logic              w_lb_hit;
   logic [DATA_W-1:0] w_lb_data;
   logic [MEM_AW-1:0] w_rd_idx;
   logic [DATA_W-1:0] w_rd_data;

   assign w_req_idx   = bus.req_addr[ADDR_W-1:2];
   assign w_ld_idx    = bus.ld_addr[ADDR_W-1:2];
   assign w_req_err   = (bus.req_addr[1:0] != 2'b00) || ({1'b0, w_req_idx} >= c_DEPTH);
   assign w_ready     = ((state_q == c_IDLE) || (state_q == c_RESP)) && !bus.flush;
   assign w_accept    = bus.req_valid && w_ready;
   assign w_wait_done = (state_q == c_WAIT) && !bus.flush && (cnt_q == 4'd0);
   assign w_ld_ok     = bus.ld_en && ({1'b0, w_ld_idx} < c_DEPTH);

   // Array read happens either at the end of WAIT or directly on accept when there are no wait states
   assign w_miss_rd = w_wait_done || (w_accept && !w_req_err && !w_lb_hit && c_ZERO_WAIT);
   assign w_rd_idx  = w_wait_done ? idx_q : w_req_idx[MEM_AW-1:0];
   assign w_rd_data = mem[w_rd_idx];

   always_ff @(posedge clk) begin
      if (w_ld_ok) begin
         mem[w_ld_idx[MEM_AW-1:0]] <= bus.ld_data;
      end
   end

`ifdef IMEM_LINEBUF_EN
   logic              lb_valid_q;
   logic [MEM_AW-1:0] lb_idx_q;
   logic [DATA_W-1:0] lb_data_q;

   assign w_lb_hit  = lb_valid_q && (lb_idx_q == w_req_idx[MEM_AW-1:0]);
   assign w_lb_data = lb_data_q;

   // A loader write landing on the word being filled wins: the captured data is already stale
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lb_valid_q <= 1'b0;
         lb_idx_q   <= '0;
         lb_data_q  <= '0;
      end else if (w_miss_rd) begin
         lb_valid_q <= !(w_ld_ok && (w_ld_idx[MEM_AW-1:0] == w_rd_idx));
         lb_idx_q   <= w_rd_idx;
         lb_data_q  <= w_rd_data;
      end else if (w_ld_ok && (w_ld_idx[MEM_AW-1:0] == lb_idx_q)) begin
         lb_valid_q <= 1'b0;
      end
   end
`else
   assign w_lb_hit  = 1'b0;
   assign w_lb_data = '0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (w_accept) begin
         if (w_req_err || w_lb_hit || c_ZERO_WAIT) begin
            state_d = c_RESP;
         end else begin
            state_d = c_WAIT;
            cnt_d   = c_WAIT_LOAD;
         end
      end else if (bus.flush || (state_q == c_RESP)) begin
         state_d = c_IDLE;
      end else if (state_q == c_WAIT) begin
         if (cnt_q == 4'd0) begin
            state_d = c_RESP;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end else if (state_q != c_IDLE) begin
         state_d = c_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= c_IDLE;
         cnt_q       <= 4'd0;
         idx_q       <= '0;
         rsp_instr_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (w_accept) begin
            idx_q <= w_req_idx[MEM_AW-1:0];
         end
         if (w_accept && w_req_err) begin
            rsp_instr_q <= '0;
            rsp_err_q   <= 1'b1;
         end else if (w_accept && w_lb_hit) begin
            rsp_instr_q <= w_lb_data;
            rsp_err_q   <= 1'b0;
         end else if (w_miss_rd) begin
            rsp_instr_q <= w_rd_data;
            rsp_err_q   <= 1'b0;
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.rsp_valid = (state_q == c_RESP) && !bus.flush;
   assign bus.rsp_instr = rsp_instr_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
